// File: rtl/mest_pro_fetch_if.sv
// Decode-side handshake bundle for the instruction fetch stage.
// Fetch (master) presents {o_instr, o_pc} with o_valid. Decode (slave) answers with i_ready.
// Valid/ready contract: a transfer happens on a rising edge where o_valid and i_ready are both 1.
// While o_valid is 1 and no transfer has happened, o_instr/o_pc hold stable.
// o_valid never depends on i_ready.
interface mest_pro_fetch_if #(
    parameter int AW        = 8,
    parameter int WORD_SIZE = 28
);
    logic                 o_valid;
    logic                 i_ready;
    logic [WORD_SIZE-1:0] o_instr;
    logic [AW-1:0]        o_pc;

    modport master (output o_valid, output o_instr, output o_pc, input i_ready);
    modport slave  (input o_valid, input o_instr, input o_pc, output i_ready);
endinterface

// File: rtl/mest_pro_fetch.sv
// Instruction fetch stage in front of the program ROM (1-cycle registered read).
// Holds the PC and drives the ROM address. Catches each ROM word one cycle after its request.
// Buffers up to two {instr, pc} pairs and delivers them to decode at one per cycle.
// A redirect pulse flushes everything and restarts fetch at the target.
// Optional feature macro: MEST_PRO_FETCH_HALT_EN.
// With it, an instruction whose top nibble equals HALT_OPCODE stops fetch and raises o_halted.
module mest_pro_fetch #(
    parameter int DEPTH     = 256,
    parameter int WORD_SIZE = 28,
    parameter logic [$clog2(DEPTH)-1:0] RESET_PC = '0
`ifdef MEST_PRO_FETCH_HALT_EN
    ,
    parameter logic [3:0] HALT_OPCODE = 4'hF
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [$clog2(DEPTH)-1:0] rom_address,
    input  logic [WORD_SIZE-1:0]     rom_data,
    input  logic                     i_redirect,
    input  logic [$clog2(DEPTH)-1:0] i_redirect_pc,
    mest_pro_fetch_if.master         dec_if
`ifdef MEST_PRO_FETCH_HALT_EN
    ,
    output logic                     o_halted
`endif
);

    localparam int AW = $clog2(DEPTH);

    // Fetch pointer and the single outstanding ROM request
    logic [AW-1:0]        pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [AW-1:0]        inflight_pc_q, inflight_pc_d;

    // Two-entry FIFO kept as a head/tail register pair. Head feeds the outputs directly.
    logic [1:0]           count_q, count_d;
    logic [WORD_SIZE-1:0] head_instr_q, head_instr_d;
    logic [AW-1:0]        head_pc_q, head_pc_d;
    logic [WORD_SIZE-1:0] tail_instr_q, tail_instr_d;
    logic [AW-1:0]        tail_pc_q, tail_pc_d;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [2:0]           occupancy;
    logic                 halt_block;

`ifdef MEST_PRO_FETCH_HALT_EN
    logic                 halt_q, halt_d;
    assign halt_block = halt_q;
    assign o_halted   = halt_q;
`else
    assign halt_block = 1'b0;
`endif

    assign rom_address    = pc_q;
    assign dec_if.o_valid = (count_q != 2'd0);
    assign dec_if.o_instr = head_instr_q;
    assign dec_if.o_pc    = head_pc_q;

    // Next-state: issue/push/pop decisions, FIFO shuffling, redirect overriding all of it
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        head_instr_d  = head_instr_q;
        head_pc_d     = head_pc_q;
        tail_instr_d  = tail_instr_q;
        tail_pc_d     = tail_pc_q;
`ifdef MEST_PRO_FETCH_HALT_EN
        halt_d        = halt_q;
`endif

        pop  = (count_q != 2'd0) & dec_if.i_ready;
        // Words already past a halt are dropped instead of buffered
        push = inflight_q & ~halt_block;

        // Slots that will be in use once this cycle's pop and pending push settle.
        // Issue only if a slot remains for the new request's data.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (occupancy < 3'd2) & ~i_redirect & ~halt_block;

        if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + AW'(1);
        end

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_instr_d = rom_data;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    tail_instr_d = rom_data;
                    tail_pc_d    = inflight_pc_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                count_d      = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_instr_d = rom_data;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    tail_instr_d = rom_data;
                    tail_pc_d    = inflight_pc_q;
                end
            end
            default: ;
        endcase

`ifdef MEST_PRO_FETCH_HALT_EN
        if (push && (rom_data[WORD_SIZE-1 -: 4] == HALT_OPCODE)) begin
            halt_d = 1'b1;
        end
`endif

        // Redirect flushes buffered and in-flight words; any pop this cycle is void
        if (i_redirect) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            pc_d       = i_redirect_pc;
`ifdef MEST_PRO_FETCH_HALT_EN
            halt_d     = 1'b0;
`endif
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            head_instr_q  <= '0;
            head_pc_q     <= '0;
            tail_instr_q  <= '0;
            tail_pc_q     <= '0;
`ifdef MEST_PRO_FETCH_HALT_EN
            halt_q        <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
            tail_instr_q  <= tail_instr_d;
            tail_pc_q     <= tail_pc_d;
`ifdef MEST_PRO_FETCH_HALT_EN
            halt_q        <= halt_d;
`endif
        end
    end

endmodule
